// File: rtl/crossing_pkg.sv
// ---------------------------------------------------------------------------
// crossing_pkg
// Shared definitions for the crossing arbiter slice:
//   - field widths of the A/D channel (opcode, address, data, tag)
//   - number of requesters and the default outstanding-request limit
//   - width of the per-requester in-flight counter
//   - the quiesce FSM state encoding
// ---------------------------------------------------------------------------
package crossing_pkg;

  localparam int OPC_W            = 3;
  localparam int ADDR_W           = 32;
  localparam int DATA_W           = 32;
  localparam int TAG_W            = 2;
  localparam int NREQ             = 2;
  localparam int MAX_INFLIGHT_DEF = 4;
  // Holds 0..4 inclusive.
  localparam int CNT_W            = 3;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_DRAIN    = 2'd1,
    ST_QUIESCED = 2'd2
  } state_e;

endpackage

// File: rtl/crossing_inflight_ctr.sv
// ---------------------------------------------------------------------------
// crossing_inflight_ctr
// Saturating up/down counter of outstanding A requests for one requester.
// Ports:
//   clock, reset      : clock, asynchronous active-high reset
//   inc               : an A request from this requester fired this cycle
//   dec               : a D response to this requester fired this cycle
//   count             : current number of outstanding requests
//   full              : count has reached MAX
//   empty             : count is zero
//   underflow         : combinational pulse, a lone dec arrived at zero
// inc and dec together leave the count unchanged. The count never wraps:
// it holds at MAX on inc and at zero on dec.
// ---------------------------------------------------------------------------
module crossing_inflight_ctr
  import crossing_pkg::*;
#(
  parameter int MAX = MAX_INFLIGHT_DEF
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             inc,
  input  logic             dec,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty,
  output logic             underflow
);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  always_comb begin
    count_d   = count_q;
    underflow = 1'b0;
    if (inc && !dec) begin
      if (count_q < CNT_W'(MAX)) count_d = count_q + 1'b1;
    end else if (dec && !inc) begin
      if (count_q == '0) underflow = 1'b1;
      else               count_d   = count_q - 1'b1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) count_q <= '0;
    else       count_q <= count_d;
  end

  assign count = count_q;
  assign full  = (count_q >= CNT_W'(MAX));
  assign empty = (count_q == '0);

endmodule

// File: rtl/crossing_arbiter.sv
// ---------------------------------------------------------------------------
// crossing_arbiter
// Two-requester round-robin arbiter in front of an async-queue crossing,
// with per-requester outstanding limits, D-channel routing and a drain
// (quiesce) handshake used before the crossing is reset.
// Ports:
//   clock, reset                  : sole clock, asynchronous active-high reset
//   req_a_*                       : per-requester A channel, requester i at slice i
//   out_a_*                       : granted A request, source = {grant_index, tag}
//   in_d_*                        : D response from the crossing
//   req_d_*                       : D response routed by in_d_source[2]
//   quiesce_req / quiesce_ack     : drain request / registered acknowledge
//
// Handshake rule on every channel: a transfer happens on a rising edge where
// valid and ready are both high; once valid is raised the sender holds it and
// its payload stable until that transfer. The A path is purely combinational
// from req_a_* to out_a_* (no added latency).
//
// Internal state useful from the hierarchy: state_q, inflight[], err_underflow.
// ---------------------------------------------------------------------------
module crossing_arbiter
  import crossing_pkg::*;
#(
  parameter int MAX_INFLIGHT = MAX_INFLIGHT_DEF
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [NREQ-1:0]        req_a_valid,
  output logic [NREQ-1:0]        req_a_ready,
  input  logic [NREQ*OPC_W-1:0]  req_a_opcode,
  input  logic [NREQ*ADDR_W-1:0] req_a_address,
  input  logic [NREQ*DATA_W-1:0] req_a_data,
  input  logic [NREQ*TAG_W-1:0]  req_a_source,
  output logic                   out_a_valid,
  input  logic                   out_a_ready,
  output logic [OPC_W-1:0]       out_a_opcode,
  output logic [ADDR_W-1:0]      out_a_address,
  output logic [DATA_W-1:0]      out_a_data,
  output logic [TAG_W:0]         out_a_source,
  input  logic                   in_d_valid,
  output logic                   in_d_ready,
  input  logic [OPC_W-1:0]       in_d_opcode,
  input  logic [TAG_W:0]         in_d_source,
  input  logic [DATA_W-1:0]      in_d_data,
  output logic [NREQ-1:0]        req_d_valid,
  input  logic [NREQ-1:0]        req_d_ready,
  output logic [OPC_W-1:0]       req_d_opcode,
  output logic [TAG_W-1:0]       req_d_source,
  output logic [DATA_W-1:0]      req_d_data,
  input  logic                   quiesce_req,
  output logic                   quiesce_ack
);

  // ---------------------------------------------------------------- state
  state_e state_q, state_d;
  logic   ptr_q, ptr_d;            // preferred requester
  logic   lock_q, lock_d;          // A presented but not yet accepted
  logic   lock_idx_q, lock_idx_d;  // requester owning the held grant
  logic   quiesce_ack_q, quiesce_ack_d;
  logic   err_underflow, err_underflow_d;

  // ---------------------------------------------------------------- counters
  logic [CNT_W-1:0] inflight [NREQ];
  logic [NREQ-1:0]  full, empty, underflow;
  logic [NREQ-1:0]  a_inc, d_dec;

  crossing_inflight_ctr #(.MAX(MAX_INFLIGHT)) u_ctr0 (
    .clock     (clock),
    .reset     (reset),
    .inc       (a_inc[0]),
    .dec       (d_dec[0]),
    .count     (inflight[0]),
    .full      (full[0]),
    .empty     (empty[0]),
    .underflow (underflow[0])
  );

  crossing_inflight_ctr #(.MAX(MAX_INFLIGHT)) u_ctr1 (
    .clock     (clock),
    .reset     (reset),
    .inc       (a_inc[1]),
    .dec       (d_dec[1]),
    .count     (inflight[1]),
    .full      (full[1]),
    .empty     (empty[1]),
    .underflow (underflow[1])
  );

  // ---------------------------------------------------------------- A path
  logic [NREQ-1:0] elig;
  logic [NREQ-1:0] grant;
  logic            g_idx;
  logic            g_vld;
  logic            a_fire;

  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      elig[i] = req_a_valid[i] && !full[i] && (state_q == ST_RUN);
    end
    g_idx = ptr_q;
    g_vld = 1'b0;
    // A held grant wins regardless of state so a request presented in RUN
    // completes even after the FSM has moved to DRAIN.
    if (lock_q) begin
      g_idx = lock_idx_q;
      g_vld = req_a_valid[lock_idx_q];
    end else if (elig[ptr_q]) begin
      g_idx = ptr_q;
      g_vld = 1'b1;
    end else if (elig[~ptr_q]) begin
      g_idx = ~ptr_q;
      g_vld = 1'b1;
    end
    grant = g_vld ? (g_idx ? 2'b10 : 2'b01) : 2'b00;
  end

  assign a_fire      = g_vld && out_a_ready;
  assign out_a_valid = g_vld;
  assign req_a_ready = grant & {NREQ{out_a_ready}};
  assign a_inc       = a_fire ? grant : '0;

  assign out_a_opcode  = g_idx ? req_a_opcode[OPC_W +: OPC_W]    : req_a_opcode[0 +: OPC_W];
  assign out_a_address = g_idx ? req_a_address[ADDR_W +: ADDR_W] : req_a_address[0 +: ADDR_W];
  assign out_a_data    = g_idx ? req_a_data[DATA_W +: DATA_W]    : req_a_data[0 +: DATA_W];
  assign out_a_source  = {g_idx, (g_idx ? req_a_source[TAG_W +: TAG_W] : req_a_source[0 +: TAG_W])};

  always_comb begin
    lock_d     = g_vld && !out_a_ready;
    lock_idx_d = g_idx;
    ptr_d      = a_fire ? ~g_idx : ptr_q;
  end

  // ---------------------------------------------------------------- D path
  logic d_idx;
  logic d_fire;

  assign d_idx        = in_d_source[TAG_W];
  assign req_d_valid  = in_d_valid ? (d_idx ? 2'b10 : 2'b01) : 2'b00;
  assign in_d_ready   = req_d_ready[d_idx];
  assign d_fire       = in_d_valid && in_d_ready;
  assign d_dec        = d_fire ? (d_idx ? 2'b10 : 2'b01) : 2'b00;
  assign req_d_opcode = in_d_opcode;
  assign req_d_source = in_d_source[TAG_W-1:0];
  assign req_d_data   = in_d_data;

  // ---------------------------------------------------------------- FSM
  always_comb begin
    state_d         = state_q;
    err_underflow_d = err_underflow | (|underflow);
    unique case (state_q)
      ST_RUN: begin
        if (quiesce_req) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (!quiesce_req)                 state_d = ST_RUN;
        else if ((&empty) && !out_a_valid) state_d = ST_QUIESCED;
      end
      ST_QUIESCED: begin
        if (!quiesce_req) state_d = ST_RUN;
      end
      default: state_d = ST_RUN;
    endcase
    // Registered copy of "next state is QUIESCED", so the ack flop is high
    // exactly while state_q is QUIESCED.
    quiesce_ack_d = (state_d == ST_QUIESCED);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q       <= ST_RUN;
      ptr_q         <= 1'b0;
      lock_q        <= 1'b0;
      lock_idx_q    <= 1'b0;
      quiesce_ack_q <= 1'b0;
      err_underflow <= 1'b0;
    end else begin
      state_q       <= state_d;
      ptr_q         <= ptr_d;
      lock_q        <= lock_d;
      lock_idx_q    <= lock_idx_d;
      quiesce_ack_q <= quiesce_ack_d;
      err_underflow <= err_underflow_d;
    end
  end

  assign quiesce_ack = quiesce_ack_q;

endmodule

// File: doc/crossing_arbiter.md
CROSSING_ARBITER -- requirements
Module: crossing_arbiter

Interface
REQ-001 SHALL have parameter MAX_INFLIGHT, default 4, the maximum outstanding A requests per requester (1..4).
REQ-002 SHALL have port clock  in  1  sole clock; all state on rising edge.
REQ-003 SHALL have port reset  in  1  asynchronous, active-high reset.
REQ-004 SHALL have ports req_a_valid in 2, req_a_ready out 2: per-requester A handshake, bit i = requester i.
REQ-005 SHALL have ports req_a_opcode in 6, req_a_address in 64, req_a_data in 64: requester i fields packed at slice i (3/32/32 bits).
REQ-006 SHALL have port req_a_source  in  4  2-bit transaction tag per requester.
REQ-007 SHALL have ports out_a_valid out 1, out_a_ready in 1: A handshake toward the async queue source.
REQ-008 SHALL have ports out_a_opcode out 3, out_a_address out 32, out_a_data out 32, out_a_source out 3: granted request; source = {grant_index, tag}.
REQ-009 SHALL have ports in_d_valid in 1, in_d_ready out 1, in_d_opcode in 3, in_d_source in 3, in_d_data in 32: D response from the async queue sink.
REQ-010 SHALL have ports req_d_valid out 2, req_d_ready in 2: per-requester D handshake.
REQ-011 SHALL have ports req_d_opcode out 3, req_d_source out 2, req_d_data out 32: D fields broadcast to both requesters.
REQ-012 SHALL have ports quiesce_req in 1, quiesce_ack out 1: drain handshake before crossing reset.

Function
REQ-013 SHALL be combinational on A: out_a_* = selected requester's fields; out_a_valid = OR of eligible req_a_valid; zero added latency.
REQ-014 SHALL treat requester i as eligible only if req_a_valid[i], inflight[i] < MAX_INFLIGHT and state = RUN.
REQ-015 SHALL arbitrate round-robin: pointer names preferred requester; if both eligible, preferred wins; if only one, it wins.
REQ-016 SHALL hold the grant while out_a_valid && !out_a_ready (no switch mid-handshake); pointer moves to the other requester only on A fire.
REQ-017 SHALL assert req_a_ready[i] = grant[i] && out_a_ready; unselected requester sees ready 0.
REQ-018 SHALL route D by in_d_source[2]: req_d_valid[k] = in_d_valid for k = in_d_source[2]; in_d_ready = req_d_ready[k]; req_d_source = in_d_source[1:0].
REQ-019 SHALL increment inflight[i] on A fire from i and decrement on D fire to i; same-cycle fire for the same i leaves count unchanged.
REQ-020 SHALL never wrap inflight: D fire at count 0 leaves 0 and sets sticky internal error bit err_underflow (visible to bench via hierarchy).
REQ-021 SHALL implement FSM RUN, DRAIN, QUIESCED: RUN->DRAIN on quiesce_req; DRAIN->QUIESCED when both inflight = 0 and no A handshake pending; QUIESCED->RUN on !quiesce_req; DRAIN->RUN if quiesce_req drops.
REQ-022 SHALL finish an A handshake already presented in RUN (valid held) even after entering DRAIN; no new grant issues in DRAIN/QUIESCED.
REQ-023 SHALL assert quiesce_ack (registered) only in QUIESCED; D routing stays active in every state.

Reset
REQ-024 SHALL on reset: state RUN, pointer 0, inflight 0, err_underflow 0, quiesce_ack 0; all ready/valid outputs follow from these (out_a_valid 0 when no request).
REQ-025 SHALL take reset mid-transaction immediately; outstanding counts are discarded.

Structure
REQ-026 SHALL place state enum, field widths (opcode 3, address/data 32, tag 2) and MAX_INFLIGHT default in shared package crossing_pkg.
REQ-027 SHALL instantiate one sub-module crossing_inflight_ctr per requester (saturating up/down counter with full/empty flags).

Verification
REQ-028 SHALL test both requesters valid continuously, out_a_ready=1 -> grants alternate 0,1,0,1; out_a_source[2] alternates.
REQ-029 SHALL test requester 0 alone, MAX_INFLIGHT=4, no D -> 4 fires, then req_a_ready[0]=0; one D with source 3'b0xx -> next A fires.
REQ-030 SHALL test out_a_ready=0 for 5 cycles with both valid -> grant and out_a_address stable all 5 cycles.
REQ-031 SHALL test D with in_d_source=3'b110, req_d_ready=2'b10 -> req_d_valid=2'b10, req_d_source=2'b10, in_d_ready=1.
REQ-032 SHALL test quiesce_req with 2 outstanding -> no new grants, quiesce_ack rises 1 cycle after last D fire; drop quiesce_req -> RUN next cycle.
REQ-033 SHALL test reset asserted mid-DRAIN with 3 outstanding -> inflight 0, state RUN, quiesce_ack 0 asynchronously.
